pipe_addsub: RTL
================

PIPE_ADDSUB -- requirements
Module: pipe_addsub

Interface
REQ-001 Parameter WIDTH, default 16: operand and result width in bits; SHALL be at least 2.
REQ-002 Parameter STAGES, default 4: number of pipeline stages; SHALL be at least 1 and SHALL divide WIDTH exactly; CHUNK = WIDTH/STAGES.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  a, b and sub are valid this cycle.
REQ-006 sub  input  1  0 = a+b, 1 = a-b.
REQ-007 a  input  WIDTH  operand A, two's complement.
REQ-008 b  input  WIDTH  operand B, two's complement.
REQ-009 stall  input  1  when 1, the whole pipeline holds its state.
REQ-010 out_valid  output  1  sum, cout and ovf are valid this cycle.
REQ-011 sum  output  WIDTH  result.
REQ-012 cout  output  1  carry out of the MSB (for sub, 1 = no borrow).
REQ-013 ovf  output  1  signed overflow of the result.

Function
REQ-014 Subtraction SHALL be a + ~b + 1: b is inverted and the initial carry-in is sub.
REQ-015 Stage k (0..STAGES-1) SHALL add bit slice [k*CHUNK +: CHUNK] of both operands plus the carry registered from stage k-1 (stage 0 uses sub).
REQ-016 Stage k SHALL register its CHUNK-bit partial sum and carry out.
REQ-017 Operand slices not yet consumed SHALL be delayed in skew registers; completed result slices SHALL be delayed in deskew registers, so all result bits align at the output.
REQ-018 Latency SHALL be exactly STAGES non-stalled cycles from an in_valid=1 sample to out_valid=1 with the matching result.
REQ-019 Throughput SHALL be one operation per non-stalled cycle; back-to-back in_valid SHALL give back-to-back out_valid, in order.
REQ-020 A valid bit SHALL travel with each operation through every stage; out_valid is the valid bit of the last stage.
REQ-021 ovf SHALL equal the carry into the MSB XOR the carry out of the MSB, registered and aligned with sum.
REQ-022 While stall=1, all data, carry and valid registers SHALL hold their values; in_valid sampled during a stall is ignored, and out_valid/sum stay constant.
REQ-023 A bubble (in_valid=0) SHALL propagate as out_valid=0; the data registers for that slot may update, but their outputs are don't-care while out_valid=0.
REQ-024 With STAGES=1 the block SHALL behave as a single registered WIDTH-bit adder/subtractor with latency 1.
REQ-025 Wrap-around: without saturation, sum SHALL be the low WIDTH bits of the true result.

Reset
REQ-026 reset_n=0 SHALL asynchronously clear all valid bits, the carry registers, sum, cout and ovf to 0, regardless of clk and stall.
REQ-027 Operations in flight when reset asserts SHALL be discarded and never appear at the output.
REQ-028 The first operation sampled on the first rising edge after reset_n rises SHALL emerge STAGES cycles later.

Configuration
REQ-029 Macro PIPE_ADDSUB_SAT_EN defined: when ovf=1, sum SHALL saturate at the output stage to 0x7F..F if the true result is positive and to 0x80..0 if it is negative (the sign is taken as the inverted MSB of the wrapped sum).
REQ-030 PIPE_ADDSUB_SAT_EN defined: ovf and cout SHALL still report the unsaturated condition.
REQ-031 PIPE_ADDSUB_SAT_EN undefined: no saturation logic is present, and sum SHALL wrap per REQ-025.

Verification (WIDTH=16, STAGES=4)
REQ-032 a=0xFFFF, b=0x0001, sub=0 -> 4 cycles later: sum=0x0000, cout=1, ovf=0 (carry ripples through all stages).
REQ-033 a=0x7FFF, b=0x0001, sub=0 -> sum=0x8000, ovf=1, cout=0; with PIPE_ADDSUB_SAT_EN sum=0x7FFF.
REQ-034 a=0x0000, b=0x0001, sub=1 -> sum=0xFFFF, cout=0, ovf=0; a=0x8000, b=0x0001, sub=1 -> ovf=1, saturated sum=0x8000.
REQ-035 Eight consecutive valid operations with stall=1 for 2 cycles mid-stream -> eight in-order results, each correct, with exactly 2 extra cycles of total latency.
REQ-036 reset_n pulsed low for one cycle with 3 operations in flight -> out_valid stays 0 until a new operation completes 4 cycles after its input.

Source files
------------

// File: rtl/pipe_addsub.sv
// pipe_addsub: STAGES-deep chunked ripple adder/subtractor; define PIPE_ADDSUB_SAT_EN for saturating sum
module pipe_addsub #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             stall,
  output logic             out_valid,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int CHUNK = WIDTH / STAGES;
  localparam int L     = STAGES - 1;
  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam int RW = WIDTH - k * CHUNK;
    logic [RW-1:0]            a_i, b_i;
    logic [(k+1)*CHUNK-1:0]   s_nx, s_r;
    logic [CHUNK:0]           add;
    logic                     c_i, v_i, c_r, v_r;
    assign add = {1'b0, a_i[CHUNK-1:0]} + {1'b0, b_i[CHUNK-1:0]} + {{CHUNK{1'b0}}, c_i};
    if (k == 0) begin : g_in
      assign a_i  = a;
      assign b_i  = b ^ {WIDTH{sub}};
      assign c_i  = sub;
      assign v_i  = in_valid;
      assign s_nx = add[CHUNK-1:0];
    end else begin : g_mid
      assign a_i  = g_st[k-1].g_op.a_r;
      assign b_i  = g_st[k-1].g_op.b_r;
      assign c_i  = g_st[k-1].c_r;
      assign v_i  = g_st[k-1].v_r;
      assign s_nx = {add[CHUNK-1:0], g_st[k-1].s_r};
    end
    if (k < L) begin : g_op
      // skew registers keep only the operand slices later stages still need
      logic [RW-CHUNK-1:0] a_r, b_r;
      always_ff @(posedge clk)
        if (!stall) begin
          a_r <= a_i[RW-1:CHUNK];
          b_r <= b_i[RW-1:CHUNK];
        end
    end
    always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
        v_r <= 1'b0;
        c_r <= 1'b0;
        s_r <= '0;
      end else if (!stall) begin
        v_r <= v_i;
        c_r <= add[CHUNK];
        s_r <= s_nx;
      end
  end
  logic             cmsb, ovf_r;
  logic [WIDTH-1:0] res;
  // carry into the MSB recovered from the MSB sum bit: c = a ^ b ^ s
  assign cmsb = g_st[L].a_i[CHUNK-1] ^ g_st[L].b_i[CHUNK-1] ^ g_st[L].add[CHUNK-1];
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) ovf_r <= 1'b0;
    else if (!stall) ovf_r <= cmsb ^ g_st[L].add[CHUNK];
  assign res       = g_st[L].s_r;
  assign out_valid = g_st[L].v_r;
  assign cout      = g_st[L].c_r;
  assign ovf       = ovf_r;
`ifdef PIPE_ADDSUB_SAT_EN
  assign sum = ovf_r ? {~res[WIDTH-1], {(WIDTH-1){res[WIDTH-1]}}} : res;
`else
  assign sum = res;
`endif
endmodule
